reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file for the pipelined RV32 core. It replaces the fixed 2-read/1-write, dual-edge file with a single-edge design. Features:
- configurable data width, register count and read-port count
- registered reads with optional write-to-read bypass
- a sequential clear engine that zeroes the array after reset or on request

It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- clear_req  in  1  one-cycle request to re-zero the whole array
- ready  out  1  high when the array is usable (RUN state)
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  packed registered read data, port i at [i*XLEN +: XLEN]
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data

## Operation
- Register 0 is not stored. Reads of address 0 always return 0. Writes to address 0 are discarded.
- The FSM has two states, CLEAR and RUN. The clear index clr_idx is AW bits wide.
  - Reset asserted: state=CLEAR, clr_idx=1, ready=0, every rd_data lane=0. Array contents are not reset asynchronously.
  - CLEAR: each edge writes 0 to mem[clr_idx] and increments clr_idx. On the edge that clears NREGS-1: state=RUN, ready=1.
  - RUN, clear_req=1: state=CLEAR, clr_idx=1, ready=0 on that edge.
  - CLEAR, clear_req=1: clr_idx restarts at 1.
- In CLEAR:
  - wr_en is ignored; no array write occurs from the write port.
  - A read with rd_en returns 0 on that lane.
- In RUN:
  - wr_en=1 and wr_addr≠0: mem[wr_addr] ← wr_data at the edge.
  - Per port i with rd_en[i]=1, rd_data lane i ← value selected from address rd_addr[i] (see Configuration for the same-cycle write case).
  - rd_en[i]=0: lane i holds its previous value.
- All NRD ports are independent. Any number of ports may read the same address in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN forces the reset values immediately. Array data written before reset is undefined until the clear completes.

## Timing
- Read latency is 1 cycle: address and enable at edge N, data visible after edge N.
- Write latency is 1 cycle: written value is readable at edge N+1 without bypass.
- After rst_n deasserts, ready rises after exactly NREGS-1 rising edges (31 for default).
- clear_req in RUN: ready drops after that edge and returns high NREGS-1 edges later.
- No combinational path from any input to any output.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, a read with rd_en[i]=1, wr_en=1, wr_addr==rd_addr[i]≠0 returns wr_data (write-first).
- REGFILE_BYPASS_EN undefined:
  - The same case returns the pre-write array value (read-first).
  - Hazard resolution is left to the forwarding unit.

## Structure
- regfile_pkg holds:
  - the state enum (RF_CLEAR, RF_RUN)
  - default constants RF_XLEN=32, RF_NREGS=32, RF_NRD=2
- One natural sub-module, reg_file_rdport. It is instantiated NRD times by generate and implements:
  - the per-lane registered mux (zero-address, CLEAR, bypass, array)
  - hold-on-disable behaviour

## Test plan
- Reset, then wait for ready. Check ready=0 for exactly 31 edges, then 1. Read all 32 addresses: every value is 0.
- RUN: write 0xDEADBEEF to x5, then read x5 on port 0 the next cycle → 0xDEADBEEF. Write 0x1234 to x0, then read x0 → 0.
- Same-edge write 0xA5A5A5A5 to x7 while port 1 reads x7 (old value 0x11):
  - with REGFILE_BYPASS_EN → 0xA5A5A5A5
  - without → 0x11, then 0xA5A5A5A5 on a re-read.
- Fill x1..x31 with their index. Pulse clear_req, and attempt a write of 0x99 to x3 during CLEAR. Expected:
  - ready low for 31 edges
  - port reads during CLEAR → 0
  - afterwards every register reads 0, including x3.
- Assert rst_n low at clear step 10:
  - rd_data and ready go to 0 immediately
  - after release, the full 31-cycle clear reruns.
- With rd_en=0 on port 1 and a write to the held address: rd_data lane 1 stays at its last value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read lane: zero-address, CLEAR and bypass override the array
// value; the lane holds its last value while disabled.
module reg_file_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  rf_state_e       i_state,
    input  logic            i_en,
    input  logic [AW-1:0]   i_addr,
    input  logic [XLEN-1:0] i_arr,
    input  logic            i_byp,
    input  logic [XLEN-1:0] i_byp_data,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            if (i_state == RF_CLEAR || i_addr == '0)
                r_data <= '0;
            else if (i_byp)
                r_data <= i_byp_data;
            else
                r_data <= i_arr;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised NRD-read / 1-write register file with a sequential clear engine.
// Define REGFILE_BYPASS_EN for write-first same-cycle reads; default is read-first.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = RF_XLEN,
    parameter  int NREGS = RF_NREGS,
    parameter  int NRD   = RF_NRD,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data
);

    rf_state_e       r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    // x0 is hardwired, so the array starts at index 1
    logic [XLEN-1:0] r_mem [NREGS-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= AW'(1);
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (clear_req) begin
                        r_clr_idx <= AW'(1);
                    end else begin
                        r_clr_idx <= r_clr_idx + AW'(1);
                        if (r_clr_idx == AW'(NREGS-1)) begin
                            r_state <= RF_RUN;
                            r_ready <= 1'b1;
                        end
                    end
                end
                RF_RUN: begin
                    if (clear_req) begin
                        r_state   <= RF_CLEAR;
                        r_clr_idx <= AW'(1);
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RF_CLEAR;
                    r_clr_idx <= AW'(1);
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // The clear engine owns the single array write port while in CLEAR.
    always_ff @(posedge clk) begin
        if (r_state == RF_CLEAR)
            r_mem[r_clr_idx] <= '0;
        else if (wr_en && wr_addr != '0)
            r_mem[wr_addr] <= wr_data;
    end

    assign ready = r_ready;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_arr;
        logic            w_byp;

        assign w_addr = rd_addr[g*AW +: AW];
        assign w_arr  = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
        assign w_byp  = wr_en && (wr_addr == w_addr);
`else
        assign w_byp  = 1'b0;
`endif

        reg_file_rdport #(.XLEN(XLEN), .AW(AW)) u_rdport (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_state    (r_state),
            .i_en       (rd_en[g]),
            .i_addr     (w_addr),
            .i_arr      (w_arr),
            .i_byp      (w_byp),
            .i_byp_data (wr_data),
            .o_data     (rd_data[g*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with a behavioural model checked every cycle.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                clear_req = 1'b0;
    logic                ready;
    logic [NRD-1:0]      rd_en = '0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;

    int n_chk = 0;
    int n_err = 0;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: edges left until usable, architectural contents, lane values.
    int              clr_left = NREGS-1;
    logic [XLEN-1:0] m_mem [NREGS];
    logic [XLEN-1:0] m_rd  [NRD] = '{default: '0};
    logic [AW-1:0]   m_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_left = NREGS-1;
            for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        end else if (clr_left > 0) begin
            for (int i = 0; i < NRD; i++) if (rd_en[i]) m_rd[i] = '0;
            if (clear_req) clr_left = NREGS-1;
            else begin
                clr_left--;
                if (clr_left == 0) for (int a = 0; a < NREGS; a++) m_mem[a] = '0;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    m_a = rd_addr[i*AW +: AW];
                    if (m_a == 0) m_rd[i] = '0;
                    else if (BYP && wr_en && wr_addr == m_a) m_rd[i] = wr_data;
                    else m_rd[i] = m_mem[m_a];
                end
            end
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (clear_req) clr_left = NREGS-1;
        end
    end

    always @(negedge clk) begin
        chk("model_ready", {31'b0, ready}, {31'b0, clr_left == 0});
        for (int i = 0; i < NRD; i++)
            chk("model_lane", rd_data[i*XLEN +: XLEN], m_rd[i]);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd(input int p, input bit en, input int a);
        rd_en[p] = en;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input bit en, input int a, input logic [31:0] d);
        wr_en = en; wr_addr = AW'(a); wr_data = d;
    endtask

    function automatic logic [31:0] lane(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic wait_ready(input string nm, input int n0);
        int n = n0;
        while (!ready && n < 100) begin
            cyc();
            n++;
        end
        chk(nm, n, 31);
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < NREGS; a += 2) begin
            rd(0, 1, a); rd(1, 1, a + 1);
            cyc();
            chk(nm, lane(0), 32'h0);
            chk(nm, lane(1), 32'h0);
        end
        rd(0, 0, 0); rd(1, 0, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_lane0", lane(0), 32'h0);
        chk("rst_lane1", lane(1), 32'h0);
        rst_n = 1'b1;
        rd(0, 1, 3); rd(1, 1, 31);
        wait_ready("init_clear_len", 0);
        read_all_zero("init_zero");

        wr(1, 5, 32'hDEADBEEF); cyc(); wr(0, 0, 0);
        rd(0, 1, 5); cyc(); rd(0, 0, 0);
        chk("x5_read", lane(0), 32'hDEADBEEF);

        wr(1, 0, 32'h1234); cyc(); wr(0, 0, 0);
        rd(0, 1, 0); cyc(); rd(0, 0, 0);
        chk("x0_read", lane(0), 32'h0);

        wr(1, 7, 32'h11); cyc();
        wr(1, 7, 32'hA5A5A5A5); rd(1, 1, 7); cyc(); wr(0, 0, 0);
        chk("x7_same_edge", lane(1), BYP ? 32'hA5A5A5A5 : 32'h11);
        cyc();
        chk("x7_reread", lane(1), 32'hA5A5A5A5);

        rd(1, 0, 7); wr(1, 7, 32'h55); cyc(); wr(0, 0, 0); cyc();
        chk("hold_lane1", lane(1), 32'hA5A5A5A5);

        for (int a = 1; a < NREGS; a++) begin
            wr(1, a, a); cyc();
        end
        wr(0, 0, 0);
        rd(0, 1, 3); cyc(); rd(0, 0, 0);
        chk("fill_x3", lane(0), 32'h3);

        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        chk("clr_ready_drop", {31'b0, ready}, 32'h0);
        wr(1, 3, 32'h99); rd(0, 1, 3); rd(1, 1, 31); cyc(); wr(0, 0, 0);
        chk("clr_read_zero", lane(0), 32'h0);
        wait_ready("req_clear_len", 1);
        rd(0, 0, 0); rd(1, 0, 0);
        read_all_zero("post_clear_zero");

        wr(1, 9, 32'hCAFE); cyc(); wr(0, 0, 0);
        rd(0, 1, 9); rd(1, 1, 9); cyc(); rd(0, 0, 0); rd(1, 0, 0);
        chk("x9_lane0", lane(0), 32'hCAFE);
        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        repeat (10) cyc();
        chk("mid_hold", lane(1), 32'hCAFE);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {31'b0, ready}, 32'h0);
        chk("async_lane0", lane(0), 32'h0);
        chk("async_lane1", lane(1), 32'h0);
        cyc();
        rst_n = 1'b1;
        wait_ready("rerun_clear_len", 0);
        rd(0, 1, 9); cyc(); rd(0, 0, 0);
        chk("x9_after_rst", lane(0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
